// File: rtl/word_byte_serializer_pkg.sv
// ---------------------------------------------------------------------------
// word_byte_serializer_pkg
// Shared definitions for the word-to-beat serializer:
//   state_t      - FSM state encoding (ST_IDLE, ST_SHIFT)
//   beat_count() - number of BW-bit beats in a DW-bit word
//   clog2_min1() - ceil(log2(n)) with a floor of 1 bit, for index counters
// ---------------------------------------------------------------------------
package word_byte_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,   // no word held
        ST_SHIFT = 1'b1    // a word is held in the shift register
    } state_t;

    function automatic int beat_count(input int dw, input int bw);
        return (bw > 0) ? (dw / bw) : 1;
    endfunction

    // A single-beat word still needs a 1-bit index so the port is never empty.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/word_byte_serializer_beat_mux.sv
// ---------------------------------------------------------------------------
// word_byte_serializer_beat_mux
// Combinational beat selector: picks beat number i_index out of a DW-bit
// word. Beat 0 is the most-significant BW bits when MSB_FIRST=1, otherwise
// the least-significant BW bits.
// Ports:
//   i_shift [DW-1:0] - word being serialized
//   i_index [IW-1:0] - beat number, 0..NB-1
//   o_beat  [BW-1:0] - selected beat
// ---------------------------------------------------------------------------
module word_byte_serializer_beat_mux #(
    parameter int DW        = 32,
    parameter int BW        = 8,
    parameter int NB        = 4,
    parameter int IW        = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic [DW-1:0] i_shift,
    input  logic [IW-1:0] i_index,
    output logic [BW-1:0] o_beat
);

    int w_sel;

    // Map beat number to word slot, then shift that slot down to bit 0.
    always_comb begin
        w_sel  = 0;
        o_beat = {BW{1'b0}};
        if (int'(i_index) < NB) begin
            if (MSB_FIRST != 0) begin
                w_sel = NB - 1 - int'(i_index);
            end else begin
                w_sel = int'(i_index);
            end
            o_beat = BW'(i_shift >> (w_sel * BW));
        end else begin
            w_sel  = 0;
            o_beat = {BW{1'b0}};
        end
    end

endmodule

// File: rtl/word_byte_serializer.sv
// ---------------------------------------------------------------------------
// word_byte_serializer
// Pops DW-bit words from an upstream one-word FIFO stage and emits each as
// DW/BW beats on a valid/ready stream. A new word is popped in the same cycle
// the last beat of the previous word is accepted, so a steady supply of
// words produces a gap-free beat stream.
// Ports:
//   Clk, ARst          - clock; asynchronous active-high reset
//   FifoData [DW-1:0]  - upstream FIFO read data
//   FifoEty            - upstream FIFO empty (0 = a word is held)
//   FifoRd             - pop strobe to the FIFO (combinational)
//   Flush              - synchronous abort of the current word
//   BeatData [BW-1:0]  - output beat (registered)
//   BeatValid          - BeatData valid
//   BeatReady          - downstream accepts the beat
//   Busy               - a word is being serialized
//   WordCnt [15:0]     - words popped, wrapping
// ---------------------------------------------------------------------------
module word_byte_serializer
    import word_byte_serializer_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BW        = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic          Clk,
    input  logic          ARst,
    input  logic [DW-1:0] FifoData,
    input  logic          FifoEty,
    output logic          FifoRd,
    input  logic          Flush,
    output logic [BW-1:0] BeatData,
    output logic          BeatValid,
    input  logic          BeatReady,
    output logic          Busy,
    output logic [15:0]   WordCnt
);

    localparam int NB = beat_count(DW, BW);
    localparam int IW = clog2_min1(NB);

    if ((BW <= 0) || (DW < BW) || ((DW % BW) != 0)) begin : g_bad_width
        $error("word_byte_serializer: DW must be a positive multiple of BW");
    end

    state_t          r_state;
    logic [DW-1:0]   r_shift;
    logic [IW-1:0]   r_index;
    logic [BW-1:0]   r_beat_data;
    logic            r_beat_valid;
    logic            r_busy;
    logic [15:0]     r_word_cnt;

    state_t          w_state_nxt;
    logic [DW-1:0]   w_shift_nxt;
    logic [IW-1:0]   w_index_nxt;
    logic [15:0]     w_word_cnt_nxt;
    logic [BW-1:0]   w_beat_nxt;
    logic            w_xfer;
    logic            w_last;
    logic            w_fifo_rd;

    // Handshake decode and pop strobe; ARst gating keeps the pop quiet in reset.
    always_comb begin
        w_xfer    = r_beat_valid & BeatReady;
        w_last    = (r_index == IW'(NB - 1));
        w_fifo_rd = ((r_state == ST_IDLE) | (w_xfer & w_last))
                    & ~FifoEty & ~Flush & ~ARst;
    end

    // Next-state logic; Flush has priority over load and transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_index_nxt    = r_index;
        w_word_cnt_nxt = r_word_cnt;
        if (Flush) begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = {IW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fifo_rd) begin
                        w_state_nxt    = ST_SHIFT;
                        w_shift_nxt    = FifoData;
                        w_index_nxt    = {IW{1'b0}};
                        w_word_cnt_nxt = r_word_cnt + 16'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_fifo_rd) begin
                        // Last beat accepted and another word waiting: reload.
                        w_state_nxt    = ST_SHIFT;
                        w_shift_nxt    = FifoData;
                        w_index_nxt    = {IW{1'b0}};
                        w_word_cnt_nxt = r_word_cnt + 16'd1;
                    end else if (w_xfer) begin
                        if (w_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_index_nxt = r_index + IW'(1);
                        end
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_index_nxt = {IW{1'b0}};
                end
            endcase
        end
    end

    // The beat is selected from the next-state word so BeatData can be registered.
    word_byte_serializer_beat_mux #(
        .DW        (DW),
        .BW        (BW),
        .NB        (NB),
        .IW        (IW),
        .MSB_FIRST (MSB_FIRST)
    ) u_beat_mux (
        .i_shift (w_shift_nxt),
        .i_index (w_index_nxt),
        .o_beat  (w_beat_nxt)
    );

    // State and output registers.
    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            r_state      <= ST_IDLE;
            r_shift      <= {DW{1'b0}};
            r_index      <= {IW{1'b0}};
            r_beat_data  <= {BW{1'b0}};
            r_beat_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_word_cnt   <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_index      <= w_index_nxt;
            r_beat_data  <= w_beat_nxt;
            r_beat_valid <= (w_state_nxt == ST_SHIFT);
            r_busy       <= (w_state_nxt == ST_SHIFT);
            r_word_cnt   <= w_word_cnt_nxt;
        end
    end

    assign FifoRd    = w_fifo_rd;
    assign BeatData  = r_beat_data;
    assign BeatValid = r_beat_valid;
    assign Busy      = r_busy;
    assign WordCnt   = r_word_cnt;

endmodule

// File: tb/tb_word_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_byte_serializer
// Two 32/8 serializers (MSB-first and LSB-first) share one emulated one-word
// FIFO and one downstream ready. A reference model tracks the held word and
// the number of beats still to send; every cycle it predicts FifoRd,
// BeatValid, Busy, BeatData and WordCnt. A third 8/8 instance is used for
// the WordCnt wrap, since it pops one word per cycle.
// ---------------------------------------------------------------------------
module tb_word_byte_serializer;

    localparam int NB = 4;

    logic        Clk = 1'b0;
    logic        ARst;
    logic        Flush;
    logic        BeatReady;
    logic        FifoEty;
    logic [31:0] FifoData;

    logic        m_rd, m_valid, m_busy;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    logic        l_rd, l_valid, l_busy;
    logic [7:0]  l_data;
    logic [15:0] l_cnt;

    logic        one_ety;
    logic [7:0]  one_fifo_data;
    logic        one_flush;
    logic        one_ready;
    logic        one_rd, one_valid, one_busy;
    logic [7:0]  one_data;
    logic [15:0] one_cnt;

    // Emulated upstream FIFO
    bit          fifo_full;
    logic [31:0] fifo_word;
    assign FifoEty  = ~fifo_full;
    assign FifoData = fifo_word;

    // Reference model state
    int          mdl_left;
    logic [31:0] mdl_word;
    logic [15:0] mdl_cnt;

    int          n_vec;
    int          n_bad;
    int          rd_seen;
    logic [7:0]  q_msb[$];
    logic [7:0]  q_lsb[$];

    typedef struct {
        logic [31:0] word;
        logic [31:0] msb_seq;
        logic [31:0] lsb_seq;
    } vec_t;

    vec_t tbl[4];

    always #5 Clk = ~Clk;

    word_byte_serializer #(.DW(32), .BW(8), .MSB_FIRST(1)) u_msb (
        .Clk(Clk), .ARst(ARst), .FifoData(FifoData), .FifoEty(FifoEty),
        .FifoRd(m_rd), .Flush(Flush), .BeatData(m_data), .BeatValid(m_valid),
        .BeatReady(BeatReady), .Busy(m_busy), .WordCnt(m_cnt)
    );

    word_byte_serializer #(.DW(32), .BW(8), .MSB_FIRST(0)) u_lsb (
        .Clk(Clk), .ARst(ARst), .FifoData(FifoData), .FifoEty(FifoEty),
        .FifoRd(l_rd), .Flush(Flush), .BeatData(l_data), .BeatValid(l_valid),
        .BeatReady(BeatReady), .Busy(l_busy), .WordCnt(l_cnt)
    );

    word_byte_serializer #(.DW(8), .BW(8), .MSB_FIRST(1)) u_one (
        .Clk(Clk), .ARst(ARst), .FifoData(one_fifo_data), .FifoEty(one_ety),
        .FifoRd(one_rd), .Flush(one_flush), .BeatData(one_data),
        .BeatValid(one_valid), .BeatReady(one_ready), .Busy(one_busy),
        .WordCnt(one_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_rd();
        return ((mdl_left == 0) || ((mdl_left == 1) && BeatReady))
               && fifo_full && !Flush && !ARst;
    endfunction

    // Beat k of the held word, k = beats already sent.
    function automatic logic [7:0] exp_beat(input bit msb_first);
        int k;
        k = NB - mdl_left;
        if (msb_first) return 8'(mdl_word >> ((NB - 1 - k) * 8));
        else           return 8'(mdl_word >> (k * 8));
    endfunction

    task automatic push(input logic [31:0] w);
        if (!fifo_full) begin
            fifo_full = 1'b1;
            fifo_word = w;
        end
    endtask

    // One clock: check at negedge, model and FIFO update just after posedge.
    task automatic cycle();
        logic rd_now;
        logic v;
        @(negedge Clk);
        rd_now = exp_rd();
        v = (mdl_left > 0);
        check("rd_msb", {31'd0, m_rd}, {31'd0, rd_now});
        check("rd_lsb", {31'd0, l_rd}, {31'd0, rd_now});
        check("valid_msb", {31'd0, m_valid}, {31'd0, v});
        check("valid_lsb", {31'd0, l_valid}, {31'd0, v});
        check("busy", {30'd0, m_busy, l_busy}, {30'd0, v, v});
        check("wordcnt", {m_cnt, l_cnt}, {mdl_cnt, mdl_cnt});
        if (v) begin
            check("data_msb", {24'd0, m_data}, {24'd0, exp_beat(1'b1)});
            check("data_lsb", {24'd0, l_data}, {24'd0, exp_beat(1'b0)});
        end
        if (m_rd) rd_seen++;
        if (m_valid && BeatReady) q_msb.push_back(m_data);
        if (l_valid && BeatReady) q_lsb.push_back(l_data);
        @(posedge Clk);
        #1;
        if (Flush) begin
            mdl_left = 0;
        end else begin
            if (mdl_left > 0 && BeatReady) mdl_left--;
            if (rd_now) begin
                mdl_word = fifo_word;
                mdl_left = NB;
                mdl_cnt++;
            end
        end
        if (rd_now) fifo_full = 1'b0;
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {a, b, c, d};
    endfunction

    task automatic collect4(input string name);
        int guard;
        guard = 0;
        while ((q_msb.size() < 4 || q_lsb.size() < 4) && guard < 24) begin
            cycle();
            guard++;
        end
        if (q_msb.size() < 4 || q_lsb.size() < 4) begin
            check({name, "_timeout"}, q_msb.size(), 4);
            while (q_msb.size() < 4) q_msb.push_back(8'h00);
            while (q_lsb.size() < 4) q_lsb.push_back(8'h00);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq;
        logic [15:0] cnt0;
        logic [7:0]  exp8[8];

        n_vec = 0; n_bad = 0; rd_seen = 0;
        ARst = 1'b1; Flush = 1'b0; BeatReady = 1'b0;
        fifo_full = 1'b0; fifo_word = 32'd0;
        mdl_left = 0; mdl_word = 32'd0; mdl_cnt = 16'd0;
        one_ety = 1'b1; one_fifo_data = 8'h5A; one_flush = 1'b0; one_ready = 1'b1;

        tbl[0] = '{32'h11223344, 32'h11223344, 32'h44332211};
        tbl[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE};
        tbl[2] = '{32'hA0A1A2A3, 32'hA0A1A2A3, 32'hA3A2A1A0};
        tbl[3] = '{32'h00FF0180, 32'h00FF0180, 32'h8001FF00};

        // Reset values
        repeat (2) @(posedge Clk);
        #1;
        check("rst_outputs", {m_rd, m_valid, m_busy, l_rd, l_valid, l_busy, one_rd, one_valid},
              32'd0);
        check("rst_data", {8'd0, m_data, l_data, one_data}, 32'd0);
        check("rst_cnt", {m_cnt, one_cnt}, 32'd0);
        ARst = 1'b0;
        repeat (2) cycle();

        // Table of single words, ready held high
        BeatReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q_msb.delete(); q_lsb.delete();
            push(tbl[i].word);
            collect4("tbl");
            seq = pack4(q_msb[0], q_msb[1], q_msb[2], q_msb[3]);
            check("tbl_msb_seq", seq, tbl[i].msb_seq);
            seq = pack4(q_lsb[0], q_lsb[1], q_lsb[2], q_lsb[3]);
            check("tbl_lsb_seq", seq, tbl[i].lsb_seq);
            cycle();
        end
        check("tbl_wordcnt", {16'd0, m_cnt}, 32'd4);

        // Back-to-back words: 8 contiguous beats, two pops
        q_msb.delete(); q_lsb.delete(); rd_seen = 0;
        push(32'hA0A1A2A3);
        cycle();
        push(32'hB0B1B2B3);
        repeat (8) cycle();
        check("b2b_pops", rd_seen, 2);
        check("b2b_beats", q_msb.size(), 8);
        exp8 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 8; i++) begin
            if (i < q_msb.size()) check("b2b_beat", {24'd0, q_msb[i]}, {24'd0, exp8[i]});
        end
        cycle();

        // Ready toggling: no duplicate or lost beat
        q_msb.delete(); q_lsb.delete();
        push(32'hDEADBEEF);
        cycle();
        for (int i = 0; i < 16 && q_lsb.size() < 4; i++) begin
            BeatReady = (i % 2 == 0);
            cycle();
        end
        if (q_lsb.size() == 4) begin
            seq = pack4(q_lsb[0], q_lsb[1], q_lsb[2], q_lsb[3]);
            check("toggle_lsb_seq", seq, 32'hEFBEADDE);
            seq = pack4(q_msb[0], q_msb[1], q_msb[2], q_msb[3]);
            check("toggle_msb_seq", seq, 32'hDEADBEEF);
        end else begin
            check("toggle_timeout", q_lsb.size(), 4);
        end
        BeatReady = 1'b1;
        cycle();

        // Flush after two beats, then the next word starts clean
        cnt0 = mdl_cnt;
        q_msb.delete(); q_lsb.delete();
        push(32'hCAFEF00D);
        cycle();
        cycle();
        cycle();
        check("flush_pre_beats", q_msb.size(), 2);
        if (q_msb.size() == 2) check("flush_pre_seq", {16'd0, q_msb[0], q_msb[1]}, 32'h0000CAFE);
        push(32'h01020304);
        Flush = 1'b1; BeatReady = 1'b0;
        cycle();
        Flush = 1'b0; BeatReady = 1'b1;
        check("flush_valid", {30'd0, m_valid, l_valid}, 32'd0);
        q_msb.delete(); q_lsb.delete();
        collect4("flush");
        seq = pack4(q_msb[0], q_msb[1], q_msb[2], q_msb[3]);
        check("flush_next_seq", seq, 32'h01020304);
        check("flush_wordcnt", {16'd0, m_cnt}, {16'd0, cnt0 + 16'd2});
        cycle();

        // Asynchronous reset mid-word
        push(32'h55667788);
        cycle();
        cycle();
        ARst = 1'b1;
        #1;
        check("arst_outputs", {m_rd, m_valid, m_busy, l_rd, l_valid, l_busy}, 32'd0);
        check("arst_data", {16'd0, m_data, l_data}, 32'd0);
        check("arst_cnt", {m_cnt, l_cnt}, 32'd0);
        fifo_full = 1'b0; mdl_left = 0; mdl_cnt = 16'd0;
        @(negedge Clk);
        ARst = 1'b0;
        @(posedge Clk);
        #1;
        repeat (3) cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            BeatReady = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) push($urandom);
            Flush = ($urandom_range(49) == 0);
            cycle();
        end
        Flush = 1'b0; BeatReady = 1'b1;
        repeat (6) cycle();

        // WordCnt wrap on the single-beat instance: one pop per cycle
        one_ety = 1'b0;
        repeat (65535) @(posedge Clk);
        #1;
        check("wrap_ffff", {16'd0, one_cnt}, 32'h0000FFFF);
        check("wrap_stream", {22'd0, one_valid, one_rd, one_data}, {22'd0, 1'b1, 1'b1, 8'h5A});
        @(posedge Clk);
        #1;
        check("wrap_zero", {16'd0, one_cnt}, 32'd0);
        one_ety = 1'b1;
        @(posedge Clk);
        #1;
        check("wrap_idle", {30'd0, one_valid, one_rd}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/word_byte_serializer.md
Name: word_byte_serializer

Overview:
- Drains the one-word FIFO stage and emits each stored DW-bit word as DW/BW narrower beats on a valid/ready byte stream.
- Sits directly downstream of the FIFO. It drives the FIFO's Rd pop strobe from the FIFO's Ety flag and ReadData.
- Feeds the byte-wide transmit path.

Parameters:
- DW, 32, word width; must match the upstream FIFO DW.
- BW, 8, beat width; DW must be an integer multiple of BW (elaboration error otherwise).
- MSB_FIRST, 1, 1 = most-significant beat first, 0 = least-significant beat first.

Ports:
- Clk  in  1  clock.
- ARst  in  1  reset, asynchronous, active-high.
- FifoData  in  DW  upstream FIFO ReadData.
- FifoEty  in  1  upstream FIFO Ety; 0 means a word is held.
- FifoRd  out  1  pop strobe to upstream FIFO Rd.
- Flush  in  1  synchronous abort of the current word.
- BeatData  out  BW  output beat.
- BeatValid  out  1  BeatData is valid.
- BeatReady  in  1  downstream accepts the beat.
- Busy  out  1  a word is being serialized.
- WordCnt  out  16  count of words popped, wrapping.

Behaviour:
- NB = DW/BW. Beat index counter width is clog2(NB), minimum 1.
- States:
  - IDLE: no word held.
  - SHIFT: a word is held in the internal shift register.
- Reset values (ARst high): state IDLE, shift register 0, beat index 0, BeatData 0, BeatValid 0, Busy 0, WordCnt 0.
- FifoRd is combinational: 1 iff (state IDLE, or last beat accepted this cycle) and FifoEty=0 and Flush=0.
  - FifoRd is never 1 while FifoEty=1, so the FIFO Unf flag must never fire.
  - FifoRd is 0 during reset, because the FIFO shares ARst and reports Ety.
- Load: at the clock edge where FifoRd=1:
  - the shift register captures FifoData;
  - beat index clears to 0;
  - state becomes SHIFT;
  - WordCnt increments (wraps 0xFFFF->0).
  - Latency: FifoEty falls at edge N -> FifoRd=1 during cycle N -> BeatValid=1 from edge N+1.
- SHIFT:
  - BeatValid=1 and Busy=1.
  - BeatData = beat[index]. With MSB_FIRST=1, beat 0 = FifoData[DW-1:DW-BW]; with MSB_FIRST=0, beat 0 = FifoData[BW-1:0].
  - BeatData is registered; it is stable while BeatValid=1 and BeatReady=0.
- Transfer occurs when BeatValid=1 and BeatReady=1 at an edge:
  - if index < NB-1: index increments and the next beat is presented next cycle;
  - if index = NB-1 and FifoEty=0: back-to-back reload in the same cycle (FifoRd=1), no bubble; state stays SHIFT;
  - if index = NB-1 and FifoEty=1: state goes to IDLE and BeatValid=0 next cycle.
- BeatReady is ignored when BeatValid=0. BeatValid never drops without a transfer except on Flush or ARst.
- Flush=1 at an edge:
  - state goes to IDLE, BeatValid 0, index 0;
  - FifoRd is suppressed that cycle;
  - WordCnt is unchanged;
  - any partially sent word is discarded;
  - a word still held in the FIFO is not popped until after Flush deasserts.
- ARst mid-word: immediate return to reset values; the partial word is lost.

Decomposition:
- Shared package: beat-count function (DW/BW), clog2 helper, state encoding constants (ST_IDLE, ST_SHIFT).
- One natural sub-module: beat_mux (combinational beat selector from shift register, index and MSB_FIRST). Keep the FSM inline.

Test Plan:
- DW=32, BW=8, MSB_FIRST=1; FIFO holds 0x11223344, BeatReady=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles; FifoRd one cycle; WordCnt=1; no Unf/Ovf.
- Two words 0xA0A1A2A3 then 0xB0B1B2B3 written so the second is in the FIFO at the last beat -> 8 contiguous beats with no bubble; FifoRd pulses at cycle 0 and cycle 4; WordCnt=2.
- MSB_FIRST=0, word 0xDEADBEEF, BeatReady toggling 1,0,1,0 -> beats EF,BE,AD,DE; BeatData held stable in every ready-low cycle; no duplicate or lost beat.
- Flush asserted after 2 beats of 0xCAFEF00D (beats CA,FE sent) -> BeatValid=0 next cycle; next FIFO word 0x01020304 serializes from 0x01; WordCnt counts both words.
- ARst pulse mid-word -> all outputs return to reset values asynchronously; after release with FIFO empty, FifoRd stays 0 and BeatValid stays 0.
- Force WordCnt to 0xFFFF via 65535 loads (or preload in sim), one more word -> WordCnt wraps to 0x0000.
